// File: rtl/mips_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
// Latency: none; declarations only.
// Backpressure: none.
package mips_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    // Temporaries t0..t7
    localparam logic [AW-1:0] T0 = 5'd8;
    localparam logic [AW-1:0] T1 = 5'd9;
    localparam logic [AW-1:0] T2 = 5'd10;
    localparam logic [AW-1:0] T3 = 5'd11;
    localparam logic [AW-1:0] T4 = 5'd12;
    localparam logic [AW-1:0] T5 = 5'd13;
    localparam logic [AW-1:0] T6 = 5'd14;
    localparam logic [AW-1:0] T7 = 5'd15;

    // Saved registers s0..s7
    localparam logic [AW-1:0] S0 = 5'd16;
    localparam logic [AW-1:0] S1 = 5'd17;
    localparam logic [AW-1:0] S2 = 5'd18;
    localparam logic [AW-1:0] S3 = 5'd19;
    localparam logic [AW-1:0] S4 = 5'd20;
    localparam logic [AW-1:0] S5 = 5'd21;
    localparam logic [AW-1:0] S6 = 5'd22;
    localparam logic [AW-1:0] S7 = 5'd23;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, three hazard lookups.
// Latency: set/clear visible the cycle after; lookups are combinational.
// Backpressure: none; set wins over clear on the same address, flush clear wins over both.
module wb_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_clr,
    input  logic              set_vld,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_vld,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] look_a,
    input  logic [ADDR_W-1:0] look_b,
    input  logic [ADDR_W-1:0] look_c,
    output logic              pend_a,
    output logic              pend_b,
    output logic              pend_c
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Next pending vector: clear on commit, then set on issue, then whole-vector flush; r0 never pending
    always_comb begin
        pending_d = pending_q;
        if (clr_vld) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_vld) begin
            pending_d[set_addr] = 1'b1;
        end
        if (flush_clr) begin
            pending_d = '0;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    // Pending vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pend_a = pending_q[look_a];
    assign pend_b = pending_q[look_b];
    assign pend_c = pending_q[look_c];

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU vs load onto the single register-file write port, tracks pending writes.
// Latency: 1 cycle from grant to reg_write; stall is combinational.
// Backpressure: ready is combinational; mem wins contention unless the ALU has lost STARVE_LIMIT cycles in a row.
module regfile_wb_sched
    import mips_pkg::*;
#(
    parameter int AW           = mips_pkg::AW,
    parameter int DW           = mips_pkg::DW,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_dest,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_dest,
    input  logic [DW-1:0] mem_data,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dest,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          stall,
    output logic          reg_write,
    output logic [AW-1:0] write_addr,
    output logic [DW-1:0] write_data
);

    localparam int            CW         = 4;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    wb_state_e     state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          reg_write_q, reg_write_d;
    logic [AW-1:0] write_addr_q, write_addr_d;
    logic [DW-1:0] write_data_q, write_data_d;

    logic in_run;
    logic starved;
    logic alu_gnt;
    logic mem_gnt;
    logic pend_a;
    logic pend_b;
    logic pend_iss;
    logic sb_set_vld;

    // Grants only in RUN and never while reset is held; ALU overrides mem once starved
    assign in_run  = rst_n && (state_q == RUN);
    assign starved = (starve_cnt_q == STARVE_MAX);
    assign alu_gnt = in_run && alu_valid && (!mem_valid || starved);
    assign mem_gnt = in_run && mem_valid && !(alu_valid && starved);

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;

    // Decode hold: RAW on either source, WAW on the issuing dest, or flush in progress
    assign stall      = pend_a || pend_b || (issue_valid && pend_iss) || (state_q == FLUSH);
    assign sb_set_vld = issue_valid && !stall;

    // Next state, starvation counter and write-port contents
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        reg_write_d  = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;

        case (state_q)
            RUN:     state_d = flush ? FLUSH : RUN;
            FLUSH:   state_d = flush ? FLUSH : RUN;
            default: state_d = RUN;
        endcase

        if ((state_q == FLUSH) || !alu_valid || alu_gnt) begin
            starve_cnt_d = '0;
        end else if (!starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // A grant to r0 is accepted but never reaches the register file
        if (alu_gnt && (alu_dest != '0)) begin
            reg_write_d  = 1'b1;
            write_addr_d = alu_dest;
            write_data_d = alu_data;
        end else if (mem_gnt && (mem_dest != '0)) begin
            reg_write_d  = 1'b1;
            write_addr_d = mem_dest;
            write_data_d = mem_data;
        end
    end

    // FSM state, counter and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            starve_cnt_q <= '0;
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            reg_write_q  <= reg_write_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
        end
    end

    assign reg_write  = reg_write_q;
    assign write_addr = write_addr_q;
    assign write_data = write_data_q;

    wb_scoreboard #(
        .ADDR_W (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_clr (state_q == FLUSH),
        .set_vld   (sb_set_vld),
        .set_addr  (issue_dest),
        .clr_vld   (reg_write_q),
        .clr_addr  (write_addr_q),
        .look_a    (rd_addr_a),
        .look_b    (rd_addr_b),
        .look_c    (issue_dest),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .pend_c    (pend_iss)
    );

endmodule
